// File: rtl/fifo_pkg.sv
// Shared definitions for the 32x8 FIFO read-side logic.
//   FIFO_DEPTH : FIFO entries (also the largest legal burst)
//   DATA_W     : FIFO data width
//   LEN_W      : burst-length counter width
//   rd_state_t : burst reader controller states
package fifo_pkg;

  localparam int unsigned FIFO_DEPTH = 32;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned LEN_W      = 6;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    FLUSH,
    DONE
  } rd_state_t;

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry, order-preserving output buffer for the burst reader.
//   clk, rst    : clock, synchronous active-high reset
//   push        : write push_data behind the current contents
//   push_data   : byte to store
//   pop         : drop the head entry (ignored when empty)
//   head_data   : current head entry
//   occupancy   : entries held, 0..2
module rd_skid_buf #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic [1:0]        occupancy
);

  logic [DATA_W-1:0] slot0;  // head
  logic [DATA_W-1:0] slot1;
  logic [1:0]        count;
  logic              do_pop;

  assign do_pop    = pop && (count != 2'd0);
  assign head_data = slot0;
  assign occupancy = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      slot0 <= '0;
      slot1 <= '0;
      count <= '0;
    end else begin
      unique case ({push, do_pop})
        2'b10: begin
          if (count == 2'd0) slot0 <= push_data;
          else               slot1 <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          // Simultaneous push/pop: the new byte lands behind whatever survives the pop.
          if (count == 2'd1) begin
            slot0 <= push_data;
          end else begin
            slot0 <= slot1;
            slot1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !do_pop && (count == 2'd2)));

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side controller for the 32x8 synchronous FIFO: on start, pops burst_len
// bytes from the FIFO and re-presents them as a valid/ready byte stream.
//   clk, rst      : clock, synchronous active-high reset
//   start         : 1-cycle pulse, begins a burst when idle
//   burst_len     : bytes to transfer (0..32), sampled with start
//   fifo_empty    : FIFO empty flag
//   fifo_wr_en    : FIFO write enable snoop (a colliding read is dropped)
//   fifo_data_op  : FIFO registered read data (valid one cycle after a read)
//   fifo_rd_en    : FIFO read request
//   m_data/m_valid/m_ready : output byte stream
//   busy          : burst in progress
//   done          : 1-cycle pulse after the last byte is accepted downstream
module fifo_burst_reader #(
  parameter int unsigned DATA_W = fifo_pkg::DATA_W,
  parameter int unsigned LEN_W  = fifo_pkg::LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic              fifo_empty,
  input  logic              fifo_wr_en,
  input  logic [DATA_W-1:0] fifo_data_op,
  output logic              fifo_rd_en,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic              done
);

  import fifo_pkg::*;

  rd_state_t        state, state_nxt;
  logic [LEN_W-1:0] issue_left;
  logic [LEN_W-1:0] out_left;
  logic             inflight;
  logic [1:0]       occupancy;
  logic [1:0]       used;
  logic [1:0]       credit;
  logic             rd_accept;
  logic             xfer;

  assign m_valid = (occupancy != 2'd0);
  assign xfer    = m_valid && m_ready;
  assign busy    = (state == READ) || (state == FLUSH);
  assign done    = (state == DONE);

  // A byte leaving this cycle frees a slot, so the buffer can sustain one
  // byte per cycle despite the one-cycle read latency.
  assign used   = occupancy + {1'b0, inflight};
  assign credit = 2'd2 + {1'b0, xfer};

  always_comb begin
    fifo_rd_en = (state == READ) && (issue_left != '0) && !fifo_empty && (used < credit);
    rd_accept  = fifo_rd_en && !fifo_empty && !fifo_wr_en;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start) state_nxt = (burst_len == '0) ? DONE : READ;
      READ:  if (issue_left == '0) state_nxt = FLUSH;
      FLUSH: if ((out_left == '0) || ((out_left == LEN_W'(1)) && xfer)) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      issue_left <= '0;
      out_left   <= '0;
      inflight   <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= rd_accept;
      if ((state == IDLE) && start) begin
        issue_left <= burst_len;
        out_left   <= burst_len;
      end else begin
        if (rd_accept && (issue_left != '0)) issue_left <= issue_left - LEN_W'(1);
        if (xfer && (out_left != '0))        out_left   <= out_left - LEN_W'(1);
      end
    end
  end

  rd_skid_buf #(
    .DATA_W(DATA_W)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight),
    .push_data(fifo_data_op),
    .pop      (xfer),
    .head_data(m_data),
    .occupancy(occupancy)
  );

  a_burst_len_legal: assert property (@(posedge clk) disable iff (rst)
    ((state == IDLE) && start) |-> (burst_len <= LEN_W'(FIFO_DEPTH)));

endmodule

// File: tb/tb_fifo_burst_reader.sv
module tb_fifo_burst_reader;

  localparam int unsigned DW = 8;
  localparam int unsigned LW = 6;

  logic          clk = 1'b0;
  logic          rst, start, fifo_empty, fifo_wr_en, fifo_rd_en;
  logic          m_valid, m_ready, busy, done;
  logic [LW-1:0] burst_len;
  logic [DW-1:0] fifo_data_op, m_data, wr_data;

  always #5 clk = ~clk;

  fifo_burst_reader #(.DATA_W(DW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .burst_len(burst_len),
    .fifo_empty(fifo_empty), .fifo_wr_en(fifo_wr_en), .fifo_data_op(fifo_data_op),
    .fifo_rd_en(fifo_rd_en), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .done(done)
  );

  // Behavioural 32x8 FIFO: registered read data, read dropped on write collision.
  logic [7:0] fmem [32];
  logic [4:0] fhead, ftail;
  logic [5:0] fcount;
  logic       wr_ok, rd_ok;
  assign fifo_empty = (fcount == 6'd0);
  assign wr_ok      = fifo_wr_en && (fcount < 6'd32);
  assign rd_ok      = fifo_rd_en && (fcount != 6'd0) && !fifo_wr_en;

  always @(posedge clk) begin
    if (rst) begin
      fhead <= '0; ftail <= '0; fcount <= '0; fifo_data_op <= '0;
    end else begin
      if (wr_ok) begin fmem[ftail] <= wr_data; ftail <= ftail + 5'd1; end
      if (rd_ok) begin fifo_data_op <= fmem[fhead]; fhead <= fhead + 5'd1; end
      fcount <= fcount + 6'(wr_ok) - 6'(rd_ok);
    end
  end

  // Monitor, sampled mid-cycle; cleared by reset.
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  rxq [$];
  int unsigned rxc [$];
  int unsigned acc_cnt, rden_cnt, done_cnt, done_cyc;

  always @(negedge clk) begin
    if (rst) begin
      rxq.delete(); rxc.delete();
      acc_cnt = 0; rden_cnt = 0; done_cnt = 0; done_cyc = 0;
    end else begin
      if (m_valid && m_ready) begin rxq.push_back(m_data); rxc.push_back(cyc); end
      if (fifo_rd_en) rden_cnt++;
      if (fifo_rd_en && !fifo_empty && !fifo_wr_en) acc_cnt++;
      if (done) begin done_cnt++; done_cyc = cyc; end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; fifo_wr_en = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic preload(input int unsigned n, input logic [7:0] base);
    for (int unsigned i = 0; i < n; i++) begin
      fifo_wr_en = 1'b1;
      wr_data    = base + 8'(i);
      tick();
    end
    fifo_wr_en = 1'b0;
  endtask

  task automatic start_burst(input int unsigned len, output int unsigned s_cyc);
    start = 1'b1; burst_len = LW'(len); s_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int unsigned budget, input string name);
    int unsigned n = 0;
    while (done_cnt == 0 && n < budget) begin tick(); n++; end
    check({name, "_done_seen"}, (done_cnt != 0) ? 1 : 0, 1);
  endtask

  task automatic check_stream(input string name, input int unsigned n, input logic [7:0] base);
    check({name, "_nbytes"}, int'(rxq.size()), int'(n));
    for (int unsigned i = 0; i < n && i < rxq.size(); i++)
      check($sformatf("%s_byte%0d", name, i), int'(rxq[i]), int'(base + 8'(i)));
  endtask

  typedef struct {
    int unsigned len;
    int unsigned preload;
    logic [7:0]  base;
    int unsigned exp_bytes;
    int unsigned exp_left;
    int unsigned exp_rden;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
    $fatal(1);
  end

  initial begin
    int unsigned s_cyc;
    vecs[0] = '{len: 4,  preload: 4,  base: 8'h10, exp_bytes: 4,  exp_left: 0, exp_rden: 4};
    vecs[1] = '{len: 32, preload: 32, base: 8'h40, exp_bytes: 32, exp_left: 0, exp_rden: 32};
    vecs[2] = '{len: 5,  preload: 7,  base: 8'h80, exp_bytes: 5,  exp_left: 2, exp_rden: 5};
    vecs[3] = '{len: 1,  preload: 1,  base: 8'hA0, exp_bytes: 1,  exp_left: 0, exp_rden: 1};
    vecs[4] = '{len: 0,  preload: 2,  base: 8'hC0, exp_bytes: 0,  exp_left: 2, exp_rden: 0};

    rst = 1'b1; start = 1'b0; burst_len = '0; fifo_wr_en = 1'b0; wr_data = '0; m_ready = 1'b1;

    // Reset state
    do_reset();
    check("rst0_rd_en", fifo_rd_en, 0);
    check("rst0_valid", m_valid, 0);
    check("rst0_data",  m_data, 0);
    check("rst0_busy",  busy, 0);
    check("rst0_done",  done, 0);

    // Table-driven bursts with m_ready held high
    for (int unsigned k = 0; k < 5; k++) begin
      string nm;
      nm = $sformatf("vec%0d", k);
      do_reset();
      m_ready = 1'b1;
      preload(vecs[k].preload, vecs[k].base);
      start_burst(vecs[k].len, s_cyc);
      wait_done(200, nm);
      tick(); tick();
      check_stream(nm, vecs[k].exp_bytes, vecs[k].base);
      check({nm, "_accepts"},   int'(acc_cnt),  int'(vecs[k].exp_bytes));
      check({nm, "_rd_en_cyc"}, int'(rden_cnt), int'(vecs[k].exp_rden));
      check({nm, "_done_cnt"},  int'(done_cnt), 1);
      check({nm, "_fifo_left"}, int'(fcount),   int'(vecs[k].exp_left));
      check({nm, "_busy_end"},  busy, 0);
      if (vecs[k].exp_bytes > 0) begin
        for (int unsigned i = 1; i < rxc.size(); i++)
          check($sformatf("%s_gap%0d", nm, i), int'(rxc[i] - rxc[i-1]), 1);
        if (rxc.size() > 0)
          check({nm, "_done_after_last"}, int'(done_cyc - rxc[rxc.size()-1]), 1);
      end else begin
        check({nm, "_done_within_2"},
              ((done_cyc > s_cyc) && (done_cyc - s_cyc <= 2)) ? 1 : 0, 1);
      end
    end

    // Backpressure: m_ready low for 5 cycles after the first valid
    do_reset();
    m_ready = 1'b0;
    preload(6, 8'h00);
    start_burst(6, s_cyc);
    for (int n = 0; n < 20 && !m_valid; n++) tick();
    check("bp_first_valid", m_valid, 1);
    repeat (5) tick();
    check("bp_rd_en_off", fifo_rd_en, 0);
    check("bp_valid_held", m_valid, 1);
    check("bp_accepts_stalled", int'(acc_cnt), 2);
    check("bp_nothing_out", int'(rxq.size()), 0);
    m_ready = 1'b1;
    wait_done(100, "bp");
    tick();
    check_stream("bp", 6, 8'h00);
    check("bp_accepts", int'(acc_cnt), 6);
    check("bp_done_cnt", int'(done_cnt), 1);

    // Write collision on the cycle of the second read
    do_reset();
    m_ready = 1'b1;
    preload(4, 8'h20);
    start_burst(4, s_cyc);
    tick();
    check("coll_rd_en_2nd", fifo_rd_en, 1);
    fifo_wr_en = 1'b1; wr_data = 8'h99;
    tick();
    fifo_wr_en = 1'b0;
    wait_done(100, "coll");
    tick();
    check_stream("coll", 4, 8'h20);
    check("coll_accepts", int'(acc_cnt), 4);
    check("coll_rd_en_cyc", int'(rden_cnt), 5);
    check("coll_fifo_left", int'(fcount), 1);

    // Empty stall mid-burst, then refill
    do_reset();
    m_ready = 1'b1;
    preload(3, 8'h50);
    start_burst(8, s_cyc);
    repeat (15) tick();
    check("stall_nbytes", int'(rxq.size()), 3);
    check("stall_busy", busy, 1);
    check("stall_rd_en", fifo_rd_en, 0);
    check("stall_no_done", int'(done_cnt), 0);
    preload(5, 8'h53);
    wait_done(100, "stall");
    repeat (3) tick();
    check_stream("stall", 8, 8'h50);
    check("stall_done_cnt", int'(done_cnt), 1);

    // Reset held 2 cycles mid-burst
    do_reset();
    m_ready = 1'b0;
    preload(6, 8'h60);
    start_burst(6, s_cyc);
    repeat (4) tick();
    check("rst_pre_valid", m_valid, 1);
    check("rst_pre_busy", busy, 1);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_valid", m_valid, 0);
    check("rst_data",  m_data, 0);
    check("rst_busy",  busy, 0);
    check("rst_done",  done, 0);
    m_ready = 1'b1;
    preload(3, 8'h70);
    repeat (10) tick();
    check("rst_idle_nbytes", int'(rxq.size()), 0);
    check("rst_idle_rd_en", int'(rden_cnt), 0);
    check("rst_idle_done", int'(done_cnt), 0);
    check("rst_idle_busy", busy, 0);
    check("rst_idle_fifo", int'(fcount), 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
